// File: rtl/axi_csr_fifo_pkg.sv
// Shared constants for the AXI4-Lite CSR + FIFO block: register offsets,
// register bit positions, AXI response codes and the register address decoder.
package axi_csr_fifo_pkg;

  localparam int unsigned CONTROL_ADDR = 32'h000;
  localparam int unsigned STATUS_ADDR  = 32'h004;

  localparam int CTRL_FIFO_EN_BIT = 0;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_UNF_BIT   = 3;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_W   = 7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    REG_CONTROL,
    REG_STATUS,
    REG_NONE
  } reg_sel_t;

  // Decodes a 32-bit word index (byte address >> 2) into a register select.
  function automatic reg_sel_t decode_reg(input logic [31:0] word_idx);
    if (word_idx == (CONTROL_ADDR >> 2)) return REG_CONTROL;
    if (word_idx == (STATUS_ADDR >> 2))  return REG_STATUS;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/axi_csr_fifo_top_sync_fifo.sv
// Synchronous FIFO core: registered pop data, level counter, empty/full flags.
// Push while full and pop while empty are ignored internally.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          empty,
  output logic                          full
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LEVEL_W'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage has no reset; only pointers and level define validity,
  // which keeps the array mappable onto RAM/LUT-RAM without a reset port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      data_out <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axi_csr_fifo_top.sv
// AXI4-Lite CSR slave (CONTROL/STATUS) around a sync_fifo core.
// Optional sticky overflow/underflow STATUS bits under AXI_CSR_FIFO_ERR_FLAGS_EN.
module axi_csr_fifo_top
  import axi_csr_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  fifo_en;
  logic                  wr_ready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  ar_ready_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  wr_hs;
  logic                  rd_hs;
  reg_sel_t              wr_sel;
  reg_sel_t              rd_sel;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [LEVEL_W-1:0]    fifo_level;

  assign wr_hs  = wr_ready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs  = ar_ready_q && S_AXI_ARVALID;
  assign wr_sel = decode_reg(32'(S_AXI_AWADDR[ADDR_WIDTH-1:2]));
  assign rd_sel = decode_reg(32'(S_AXI_ARADDR[ADDR_WIDTH-1:2]));

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .push     (fifo_en && wr_en),
    .pop      (fifo_en && rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .level    (fifo_level),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

`ifdef AXI_CSR_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;
  logic status_w1c;

  assign status_w1c = wr_hs && (wr_sel == REG_STATUS) && S_AXI_WSTRB[0];

  // A new error event in the same cycle as a W1C wins, so it is never lost.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (fifo_en && wr_en && fifo_full) ||
               (ovf_q && !(status_w1c && S_AXI_WDATA[STAT_OVF_BIT]));
      unf_q <= (fifo_en && rd_en && fifo_empty) ||
               (unf_q && !(status_w1c && S_AXI_WDATA[STAT_UNF_BIT]));
    end
  end
`endif

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    status_word = '0;
    status_word[STAT_EMPTY_BIT] = fifo_empty;
    status_word[STAT_FULL_BIT]  = fifo_full;
    status_word[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
`ifdef AXI_CSR_FIFO_ERR_FLAGS_EN
    status_word[STAT_OVF_BIT] = ovf_q;
    status_word[STAT_UNF_BIT] = unf_q;
`endif
    rd_word = '0;
    case (rd_sel)
      REG_CONTROL: rd_word[CTRL_FIFO_EN_BIT] = fifo_en;
      REG_STATUS:  rd_word = status_word;
      default:     rd_word = '0;
    endcase
  end

  // Write channel: AW and W are accepted together, one response at a time.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      fifo_en    <= 1'b0;
    end else begin
      wr_ready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !wr_ready_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
        if ((wr_sel == REG_CONTROL) && S_AXI_WSTRB[0])
          fifo_en <= S_AXI_WDATA[CTRL_FIFO_EN_BIT];
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      ar_ready_q <= S_AXI_ARVALID && !rvalid_q && !ar_ready_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= (rd_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
        rdata_q  <= rd_word;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = wr_ready_q;
  assign S_AXI_WREADY  = wr_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  // Byte-offset address bits and most data/strobe bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_WDATA, S_AXI_WSTRB, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_csr_fifo_top.sv
// Self-checking bench for axi_csr_fifo_top: register vector table, directed
// FIFO sequences and a randomized run against a queue-based reference model.
module tb_axi_csr_fifo_top;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
`ifdef AXI_CSR_FIFO_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic            ACLK = 1'b0;
  logic            ARESETn = 1'b0;
  logic [AW-1:0]   S_AXI_AWADDR = '0;
  logic            S_AXI_AWVALID = 1'b0;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA = '0;
  logic [DW/8-1:0] S_AXI_WSTRB = '0;
  logic            S_AXI_WVALID = 1'b0;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY = 1'b0;
  logic [AW-1:0]   S_AXI_ARADDR = '0;
  logic            S_AXI_ARVALID = 1'b0;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY = 1'b0;
  logic            wr_en = 1'b0;
  logic            rd_en = 1'b0;
  logic [DW-1:0]   data_in = '0;
  logic [DW-1:0]   data_out;

  axi_csr_fifo_top #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .data_in       (data_in),
    .data_out      (data_out)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue plus the software-visible flags.
  logic [DW-1:0] model_q [$];
  bit            model_en  = 1'b0;
  bit            model_ovf = 1'b0;
  bit            model_unf = 1'b0;
  logic [DW-1:0] exp_dout  = '0;

  typedef struct {
    bit          is_write;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0]    = (model_q.size() == 0);
    s[1]    = (model_q.size() == DEPTH);
    s[14:8] = 7'(model_q.size());
    if (FLAGS) begin
      s[2] = model_ovf;
      s[3] = model_unf;
    end
    return s;
  endfunction

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit got;
    int lat;
    got = 1'b0;
    lat = 0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge ACLK); #1;
      lat++;
      got = S_AXI_AWREADY && S_AXI_WREADY;
    end
    if (!got) begin
      check("awready_timeout", 32'd0, 32'd1);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      resp = 2'b11;
      return;
    end
    check("aw_latency", lat, 1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("awready_pulse", 32'(S_AXI_AWREADY), 32'd0);
    check("bvalid_on_hs", 32'(S_AXI_BVALID), 32'd1);
    got = S_AXI_BVALID;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge ACLK); #1;
      got = S_AXI_BVALID;
    end
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    check("bvalid_clear", 32'(S_AXI_BVALID), 32'd0);
    if (a[11:2] == 10'd0 && s[0]) model_en = d[0];
    if (a[11:2] == 10'd1 && s[0]) begin
      if (d[2]) model_ovf = 1'b0;
      if (d[3]) model_unf = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit got;
    int lat;
    got = 1'b0;
    lat = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge ACLK); #1;
      lat++;
      got = S_AXI_ARREADY;
    end
    if (!got) begin
      check("arready_timeout", 32'd0, 32'd1);
      S_AXI_ARVALID = 1'b0;
      d = 'x; resp = 2'b11;
      return;
    end
    check("ar_latency", lat, 1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    check("rvalid_on_hs", 32'(S_AXI_RVALID), 32'd1);
    got = S_AXI_RVALID;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge ACLK); #1;
      got = S_AXI_RVALID;
    end
    d = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    check("rvalid_clear", 32'(S_AXI_RVALID), 32'd0);
  endtask

  task automatic check_status(input string name);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(12'h004, d, r);
    check({name, "_rresp"}, 32'(r), 32'd0);
    check(name, d, model_status());
  endtask

  // One FIFO-port cycle; data_out is compared right after the edge.
  task automatic fifo_cycle(input bit w, input bit r, input logic [31:0] d);
    bit was_full, was_empty;
    wr_en = w; rd_en = r; data_in = d;
    @(posedge ACLK); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (model_en) begin
      if (w && was_full)  model_ovf = 1'b1;
      if (r && was_empty) model_unf = 1'b1;
      if (r && !was_empty) exp_dout = model_q.pop_front();
      if (w && !was_full)  model_q.push_back(d);
    end
    check("data_out", data_out, exp_dout);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;

    repeat (5) @(posedge ACLK);
    #1;
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
    check("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
    check("rst_resps",   32'({S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
    check("rst_rdata",   S_AXI_RDATA, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // Register map vectors: {write?, addr, wdata, strb, resp, rdata}.
    tbl[0]  = '{1'b0, 12'h004, 32'h0,         4'h0, 2'b00, 32'h0000_0001};
    tbl[1]  = '{1'b0, 12'h000, 32'h0,         4'h0, 2'b00, 32'h0000_0000};
    tbl[2]  = '{1'b1, 12'h008, 32'h1,         4'hF, 2'b10, 32'h0};
    tbl[3]  = '{1'b0, 12'h000, 32'h0,         4'h0, 2'b00, 32'h0000_0000};
    tbl[4]  = '{1'b0, 12'h008, 32'h0,         4'h0, 2'b10, 32'h0000_0000};
    tbl[5]  = '{1'b1, 12'h000, 32'h1,         4'h0, 2'b00, 32'h0};
    tbl[6]  = '{1'b0, 12'h000, 32'h0,         4'h0, 2'b00, 32'h0000_0000};
    tbl[7]  = '{1'b1, 12'h000, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
    tbl[8]  = '{1'b0, 12'h000, 32'h0,         4'h0, 2'b00, 32'h0000_0001};
    tbl[9]  = '{1'b1, 12'h004, 32'h0,         4'hF, 2'b00, 32'h0};
    tbl[10] = '{1'b0, 12'h004, 32'h0,         4'h0, 2'b00, 32'h0000_0001};
    tbl[11] = '{1'b1, 12'h000, 32'h0,         4'h1, 2'b00, 32'h0};
    tbl[12] = '{1'b0, 12'h000, 32'h0,         4'h0, 2'b00, 32'h0000_0000};
    tbl[13] = '{1'b0, 12'hFFC, 32'h0,         4'h0, 2'b10, 32'h0000_0000};

    foreach (tbl[i]) begin
      if (tbl[i].is_write) begin
        axi_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, rsp);
        check($sformatf("vec%0d_bresp", i), 32'(rsp), 32'(tbl[i].exp_resp));
      end else begin
        axi_read(tbl[i].addr, rd, rsp);
        check($sformatf("vec%0d_rresp", i), 32'(rsp), 32'(tbl[i].exp_resp));
        check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      end
    end

    // Disabled FIFO blocks pushes.
    for (int i = 0; i < 3; i++) fifo_cycle(1'b1, 1'b0, 32'hA0 + i);
    axi_read(12'h004, rd, rsp);
    check("dis_push_status", rd, 32'h0000_0001);

    // Enable, push 1..5 every other cycle, then drain in order.
    axi_write(12'h000, 32'h1, 4'h1, rsp);
    check("en_bresp", 32'(rsp), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      fifo_cycle(1'b1, 1'b0, i);
      fifo_cycle(1'b0, 1'b0, 32'h0);
    end
    axi_read(12'h004, rd, rsp);
    check("level5_status", rd, 32'h0000_0500);
    for (int i = 1; i <= 5; i++) begin
      fifo_cycle(1'b0, 1'b1, 32'h0);
      check($sformatf("pop_seq%0d", i), data_out, i);
    end
    axi_read(12'h004, rd, rsp);
    check("drained_status", rd, 32'h0000_0001);
    fifo_cycle(1'b0, 1'b1, 32'h0);
    check("empty_pop_hold", data_out, 32'd5);
    check_status("underflow_status");
    axi_write(12'h004, 32'hFFFF_FFFF, 4'hF, rsp);
    check("status_w1c_bresp", 32'(rsp), 32'd0);
    check_status("after_w1c_status");

    // Fill to 16, then a dropped 17th push.
    for (int i = 0; i < DEPTH; i++) fifo_cycle(1'b1, 1'b0, 32'h100 + i);
    axi_read(12'h004, rd, rsp);
    check("full_status", rd, 32'h0000_1002);
    fifo_cycle(1'b1, 1'b0, 32'hDEAD);
    axi_read(12'h004, rd, rsp);
    check("overflow_status", rd, FLAGS ? 32'h0000_1006 : 32'h0000_1002);
    axi_write(12'h004, 32'h4, 4'h1, rsp);
    axi_read(12'h004, rd, rsp);
    check("ovf_clear_status", rd, 32'h0000_1002);
    for (int i = 0; i < DEPTH; i++) fifo_cycle(1'b0, 1'b1, 32'h0);
    check("last_of_full", data_out, 32'h10F);
    fifo_cycle(1'b0, 1'b1, 32'h0);
    axi_read(12'h004, rd, rsp);
    check("underflow_bit", rd, FLAGS ? 32'h0000_0009 : 32'h0000_0001);
    axi_write(12'h004, 32'h8, 4'h1, rsp);

    // Simultaneous push/pop at level 3 keeps level and order.
    for (int i = 0; i < 3; i++) fifo_cycle(1'b1, 1'b0, 32'h10 + i);
    fifo_cycle(1'b1, 1'b1, 32'h13);
    check("simul_first_out", data_out, 32'h10);
    fifo_cycle(1'b1, 1'b1, 32'h14);
    axi_read(12'h004, rd, rsp);
    check("simul_level3", rd, 32'h0000_0300);
    for (int i = 0; i < 3; i++) begin
      fifo_cycle(1'b0, 1'b1, 32'h0);
      check($sformatf("simul_order%0d", i), data_out, 32'h12 + i);
    end
    // Empty with both requests: only the push happens.
    fifo_cycle(1'b1, 1'b1, 32'h77);
    check_status("empty_both_status");
    fifo_cycle(1'b0, 1'b1, 32'h0);
    check("empty_both_data", data_out, 32'h77);

    // Disable retains contents.
    fifo_cycle(1'b1, 1'b0, 32'h55);
    axi_write(12'h000, 32'h0, 4'h1, rsp);
    fifo_cycle(1'b0, 1'b1, 32'h0);
    check("dis_pop_hold", data_out, 32'h77);
    axi_write(12'h000, 32'h1, 4'h1, rsp);
    fifo_cycle(1'b0, 1'b1, 32'h0);
    check("retained_word", data_out, 32'h55);

    // Randomized traffic against the model.
    for (int it = 0; it < 600; it++) begin
      int sel, wp;
      sel = $urandom_range(0, 99);
      wp  = ((it / 60) % 2) ? 75 : 25;
      if (sel < 2) begin
        axi_write(12'h000, ($urandom_range(0, 3) == 0) ? 32'h0 : 32'h1, 4'h1, rsp);
      end else if (sel < 4) begin
        axi_write(12'h004, $urandom, 4'h1, rsp);
      end else if (sel < 8) begin
        check_status("rand_status");
      end else begin
        fifo_cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp), $urandom);
      end
    end

    // Asynchronous reset mid-read drops the transaction and clears state.
    if (model_q.size() == 0) fifo_cycle(1'b1, 1'b0, 32'h99);
    fifo_cycle(1'b0, 1'b1, 32'h0);
    S_AXI_ARADDR = 12'h004; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    #1;
    check("async_rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("async_rst_data_out", data_out, 32'd0);
    S_AXI_ARVALID = 1'b0;
    @(posedge ACLK); #1;
    check("async_rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    ARESETn = 1'b1;
    model_q.delete();
    model_en = 1'b0; model_ovf = 1'b0; model_unf = 1'b0; exp_dout = '0;
    @(posedge ACLK); #1;
    check_status("post_rst_status");
    axi_read(12'h000, rd, rsp);
    check("post_rst_control", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
